// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES constants and round-function helpers.
//   - keylen codes and round counts (10 / 12 / 14)
//   - encipher control FSM state encoding
//   - GF(2^8) helpers gm2/gm3, single-column MixColumns (mixw),
//     full-block mixcolumns, shiftrows and addroundkey
// Byte order: byte 0 = bits 127:120, column-major (FIPS-197).
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_192 = 2'b01;
  localparam logic [1:0] KEYLEN_256 = 2'b10;

  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES192_ROUNDS = 4'd12;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_SBOX = 2'd1,
    CTRL_MAIN = 2'd2
  } ctrl_state_t;

  // Block viewed as 16 bytes; element 15 is byte 0 (bits 127:120).
  typedef logic [15:0][7:0] aes_state_t;

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    return gm2(b) ^ b;
  endfunction

  // MixColumns on one column, row 0 in bits 31:24.
  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
            b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
            gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] blk);
    return {mixw(blk[127:96]), mixw(blk[95:64]), mixw(blk[63:32]), mixw(blk[31:0])};
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4).
  // Byte k of the block lives in st[15-k].
  function automatic logic [127:0] shiftrows(input logic [127:0] blk);
    aes_state_t st;
    st = blk;
    return {st[15], st[10], st[5],  st[0],
            st[11], st[6],  st[1],  st[12],
            st[7],  st[2],  st[13], st[8],
            st[3],  st[14], st[9],  st[4]};
  endfunction

  function automatic logic [127:0] addroundkey(input logic [127:0] blk,
                                               input logic [127:0] key);
    return blk ^ key;
  endfunction

endpackage

// File: rtl/aes_encipher_block_sword.sv
// ---------------------------------------------------------------------------
// aes_sbox / aes_encipher_block_sword
// aes_sbox: forward AES S-box, combinational ROM.
//   addr [7:0] in  - byte to substitute
//   data [7:0] out - substituted byte
// aes_encipher_block_sword: 32-bit SubWord built from four aes_sbox.
//   word_in  [31:0] in  - word to substitute
//   word_out [31:0] out - byte-wise S-box result
// ---------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  // Entry 0x00 sits in the top byte of the table.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_hi;

  assign bit_hi = 11'd2047 - {addr, 3'b000};
  assign data   = SBOX_TABLE[bit_hi -: 8];

endmodule

module aes_encipher_block_sword (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .addr (word_in[8*gi +: 8]),
      .data (word_out[8*gi +: 8])
    );
  end

endmodule

// File: rtl/aes_encipher_block.sv
// ---------------------------------------------------------------------------
// aes_encipher_block
// Iterative AES encipher datapath. One S-box word per cycle (4 cycles),
// then ShiftRows/MixColumns/AddRoundKey in one cycle: 5 cycles per round.
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   next           in   start pulse, accepted only while ready=1
//   keylen [1:0]   in   00 AES-128, 01 AES-192 (optional), 10 AES-256
//   round_key_addr out  round-key index into the shared key memory
//   round_key      in   key word for round_key_addr, same cycle
//   block          in   plaintext, sampled on the accepting edge
//   new_block      out  ciphertext (block register, always visible)
//   ready          out  idle and result valid
// Build option: define AES_ENC_KEYLEN192_EN to accept keylen=01 (12 rounds).
// ---------------------------------------------------------------------------
module aes_encipher_block
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic [1:0]   keylen,
  output logic [3:0]   round_key_addr,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  ctrl_state_t  state_q, state_d;
  logic [127:0] block_q, block_d;
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic [1:0]   sword_ctr_q, sword_ctr_d;
  logic [1:0]   keylen_q, keylen_d;
  logic         ready_q, ready_d;

  logic         keylen_ok;
  logic [3:0]   num_rounds;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;

  aes_encipher_block_sword u_sword (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  always_comb begin
    keylen_ok = (keylen == KEYLEN_128) || (keylen == KEYLEN_256);
`ifdef AES_ENC_KEYLEN192_EN
    keylen_ok = keylen_ok || (keylen == KEYLEN_192);
`endif
  end

  always_comb begin
    num_rounds = AES128_ROUNDS;
    if (keylen_q == KEYLEN_256) begin
      num_rounds = AES256_ROUNDS;
    end
`ifdef AES_ENC_KEYLEN192_EN
    else if (keylen_q == KEYLEN_192) begin
      num_rounds = AES192_ROUNDS;
    end
`endif
  end

  // Word w0 is bits 127:96.
  always_comb begin
    case (sword_ctr_q)
      2'd0:    sub_in = block_q[127:96];
      2'd1:    sub_in = block_q[95:64];
      2'd2:    sub_in = block_q[63:32];
      default: sub_in = block_q[31:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    block_d     = block_q;
    round_ctr_d = round_ctr_q;
    sword_ctr_d = sword_ctr_q;
    keylen_d    = keylen_q;
    ready_d     = ready_q;

    case (state_q)
      CTRL_IDLE: begin
        if (next && keylen_ok) begin
          // Round key 0 is on the bus while idle.
          block_d     = addroundkey(block, round_key);
          keylen_d    = keylen;
          round_ctr_d = 4'd1;
          sword_ctr_d = 2'd0;
          ready_d     = 1'b0;
          state_d     = CTRL_SBOX;
        end
      end

      CTRL_SBOX: begin
        case (sword_ctr_q)
          2'd0:    block_d[127:96] = sub_out;
          2'd1:    block_d[95:64]  = sub_out;
          2'd2:    block_d[63:32]  = sub_out;
          default: block_d[31:0]   = sub_out;
        endcase
        sword_ctr_d = sword_ctr_q + 2'd1;
        if (sword_ctr_q == 2'd3) begin
          state_d = CTRL_MAIN;
        end
      end

      CTRL_MAIN: begin
        if (round_ctr_q < num_rounds) begin
          block_d     = addroundkey(mixcolumns(shiftrows(block_q)), round_key);
          round_ctr_d = round_ctr_q + 4'd1;
          sword_ctr_d = 2'd0;
          state_d     = CTRL_SBOX;
        end else begin
          // Final round has no MixColumns.
          block_d = addroundkey(shiftrows(block_q), round_key);
          ready_d = 1'b1;
          state_d = CTRL_IDLE;
        end
      end

      default: begin
        state_d = CTRL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CTRL_IDLE;
      block_q     <= '0;
      round_ctr_q <= 4'd0;
      sword_ctr_q <= 2'd0;
      keylen_q    <= KEYLEN_128;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      round_ctr_q <= round_ctr_d;
      sword_ctr_q <= sword_ctr_d;
      keylen_q    <= keylen_d;
      ready_q     <= ready_d;
    end
  end

  assign round_key_addr = (state_q == CTRL_IDLE) ? 4'd0 : round_ctr_q;
  assign new_block      = block_q;
  assign ready          = ready_q;

endmodule

// File: tb/tb_aes_encipher_block.sv
// ---------------------------------------------------------------------------
// tb_aes_encipher_block
// Directed FIPS-197 vectors against aes_encipher_block. A key-memory model
// expands the cipher key and serves round_key from round_key_addr.
// Honours AES_ENC_KEYLEN192_EN for the keylen=01 step.
// ---------------------------------------------------------------------------
module tb_aes_encipher_block;

  logic         clk = 1'b0;
  logic         reset;
  logic         next;
  logic [1:0]   keylen;
  logic [3:0]   round_key_addr;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  logic [127:0] rk_mem [0:15];
  int           n_asserts = 0;
  int           n_fail    = 0;

  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic [2047:0] sbox_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always #5 clk = ~clk;

  assign round_key = rk_mem[round_key_addr];

  aes_encipher_block dut (
    .clk            (clk),
    .reset          (reset),
    .next           (next),
    .keylen         (keylen),
    .round_key_addr (round_key_addr),
    .round_key      (round_key),
    .block          (block),
    .new_block      (new_block),
    .ready          (ready)
  );

  function automatic logic [7:0] sb(input logic [7:0] b);
    int hi;
    hi = 2047 - 8 * int'(b);
    return sbox_tab[hi -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
  endfunction

  // FIPS-197 key expansion into the key-memory model.
  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk_mem[r] = '0;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start one operation and follow it to completion. At cycle inj (counted
  // from the accepting edge) next is re-asserted with a different block.
  task automatic run(input string tag, input logic [127:0] pt, input logic [1:0] kl,
                     input int nr, input int inj, input logic [127:0] exp_ct);
    int cycles;
    chk({tag, " idle addr"}, 128'(round_key_addr), 128'd0);
    block  = pt;
    keylen = kl;
    next   = 1'b1;
    tick;
    next   = 1'b0;
    keylen = 2'b11;
    block  = '1;
    chk({tag, " busy"}, 128'(ready), 128'd0);
    cycles = 0;
    while (!ready && cycles < 5 * nr + 20) begin
      chk({tag, " addr"}, 128'(round_key_addr), 128'(cycles / 5 + 1));
      next = (cycles == inj);
      if (next) begin
        keylen = kl;
        block  = ~pt;
      end
      tick;
      cycles++;
    end
    next = 1'b0;
    $display("%s: ready after %0d cycles, new_block=%h", tag, cycles, new_block);
    chk({tag, " latency"}, 128'(cycles), 128'(5 * nr));
    chk({tag, " ct"}, new_block, exp_ct);
    chk({tag, " done addr"}, 128'(round_key_addr), 128'd0);
    tick;
    chk({tag, " hold ready"}, 128'(ready), 128'd1);
    chk({tag, " hold ct"}, new_block, exp_ct);
  endtask

  initial begin
    reset  = 1'b1;
    next   = 1'b0;
    keylen = 2'b00;
    block  = '0;
    expand(KEY_C1, 4);
    tick;
    chk("reset ready", 128'(ready), 128'd1);
    chk("reset block", new_block, 128'd0);
    tick;
    reset = 1'b0;
    tick;
    chk("post-reset ready", 128'(ready), 128'd1);
    chk("post-reset block", new_block, 128'd0);
    chk("post-reset addr", 128'(round_key_addr), 128'd0);

    // Reserved keylen must not start anything.
    block  = PT_C;
    keylen = 2'b11;
    next   = 1'b1;
    tick;
    next   = 1'b0;
    $display("keylen=11 start: ready=%0b new_block=%h", ready, new_block);
    chk("kl11 ready", 128'(ready), 128'd1);
    chk("kl11 block", new_block, 128'd0);

    run("C1 aes128", PT_C, 2'b00, 10, -1, CT_C1);

`ifdef AES_ENC_KEYLEN192_EN
    expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    run("C2 aes192", PT_C, 2'b01, 12, -1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    block  = PT_C;
    keylen = 2'b11;
    next   = 1'b1;
    tick;
    next   = 1'b0;
    chk("kl11 again ready", 128'(ready), 128'd1);
    chk("kl11 again block", new_block, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
`else
    block  = PT_B;
    keylen = 2'b01;
    next   = 1'b1;
    tick;
    next   = 1'b0;
    $display("keylen=01 start: ready=%0b new_block=%h", ready, new_block);
    chk("kl01 ready", 128'(ready), 128'd1);
    chk("kl01 block", new_block, CT_C1);
    keylen = 2'b11;
    next   = 1'b1;
    tick;
    next   = 1'b0;
    chk("kl11 again ready", 128'(ready), 128'd1);
    chk("kl11 again block", new_block, CT_C1);
`endif

    expand(KEY_B, 4);
    run("AppB aes128", PT_B, 2'b00, 10, -1, CT_B);

    // next asserted on the edge where ready rises must be ignored.
    expand(KEY_C3, 8);
    run("C3 aes256", PT_C, 2'b10, 14, 69, CT_C3);

    // next while busy must be ignored.
    expand(KEY_C1, 4);
    run("C1 busy-next", PT_C, 2'b00, 10, 20, CT_C1);

    // Abort mid-run with asynchronous reset.
    expand(KEY_B, 4);
    block  = PT_B;
    keylen = 2'b00;
    next   = 1'b1;
    tick;
    next   = 1'b0;
    repeat (22) tick;
    reset = 1'b1;
    #1;
    $display("abort: ready=%0b new_block=%h", ready, new_block);
    chk("abort ready", 128'(ready), 128'd1);
    chk("abort block", new_block, 128'd0);
    tick;
    reset = 1'b0;
    tick;
    run("AppB after abort", PT_B, 2'b00, 10, -1, CT_B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
